// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Fetch stage: PC, in-order imem req/gnt/rvalid, DEPTH-entry FIFO to decode.
// Rev    : 1.0
// ============================================================================
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [ADDR_WIDTH-1:0] pc_plus4_o,
   input  logic                  instr_ready_i
);

   localparam int                    CW         = $clog2(DEPTH + 1);
   localparam int                    PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                    C_LAST_INT = DEPTH - 1;
   localparam logic [PW-1:0]         C_LAST     = C_LAST_INT[PW-1:0];
   localparam logic [CW:0]           C_DEPTH    = DEPTH[CW:0];
   localparam logic [DATA_WIDTH-1:0] C_NOP      = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDR_WIDTH-1:0] C_FOUR     = ADDR_WIDTH'(4);
   localparam logic [CW-1:0]         C_ONE      = CW'(1);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         discard_q, discard_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [PW-1:0]         ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;
   logic [DATA_WIDTH-1:0] fifo_instr_q [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_instr_d [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_q    [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc_d    [DEPTH];
   logic [ADDR_WIDTH-1:0] ifq_addr_q   [DEPTH];
   logic [ADDR_WIDTH-1:0] ifq_addr_d   [DEPTH];

   logic          pop, grant, rsp, push;
   logic [CW:0]   credit;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == C_LAST) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      instr_valid_o = (count_q != '0);
      instr_o       = instr_valid_o ? fifo_instr_q[fifo_rd_q] : C_NOP;
      pc_o          = instr_valid_o ? fifo_pc_q[fifo_rd_q] : '0;
      pc_plus4_o    = instr_valid_o ? fifo_pc_q[fifo_rd_q] + C_FOUR : '0;
      imem_addr_o   = pc_q;

      pop    = instr_valid_o & instr_ready_i & ~redirect_i;
      // Buffered words plus in-flight requests never exceed DEPTH, so no overflow.
      credit = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
      imem_req_o = ~rst_i & ~redirect_i & (credit < C_DEPTH);
      grant  = imem_req_o & imem_gnt_i;
      rsp    = imem_rvalid_i & (outstanding_q != '0);
      push   = rsp & (discard_q == '0) & ~redirect_i;
   end

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q;
      fifo_rd_d     = fifo_rd_q;
      fifo_wr_d     = fifo_wr_q;
      ifq_rd_d      = ifq_rd_q;
      ifq_wr_d      = ifq_wr_q;
      fifo_instr_d  = fifo_instr_q;
      fifo_pc_d     = fifo_pc_q;
      ifq_addr_d    = ifq_addr_q;

      if (grant && !rsp) begin
         outstanding_d = outstanding_q + C_ONE;
      end else if (!grant && rsp) begin
         outstanding_d = outstanding_q - C_ONE;
      end

      if (grant) begin
         ifq_addr_d[ifq_wr_q] = pc_q;
         ifq_wr_d             = ptr_inc(ifq_wr_q);
      end
      if (rsp) begin
         ifq_rd_d = ptr_inc(ifq_rd_q);
      end

      if (redirect_i) begin
         // Everything still in flight belongs to the old path and must be dropped.
         pc_d      = redirect_pc_i;
         count_d   = '0;
         fifo_rd_d = '0;
         fifo_wr_d = '0;
         discard_d = rsp ? outstanding_q - C_ONE : outstanding_q;
      end else begin
         if (grant) begin
            pc_d = pc_q + C_FOUR;
         end
         if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - C_ONE;
         end
         if (push) begin
            fifo_instr_d[fifo_wr_q] = imem_rdata_i;
            fifo_pc_d[fifo_wr_q]    = ifq_addr_q[ifq_rd_q];
            fifo_wr_d               = ptr_inc(fifo_wr_q);
         end
         if (pop) begin
            fifo_rd_d = ptr_inc(fifo_rd_q);
         end
         if (push && !pop) begin
            count_d = count_q + C_ONE;
         end else if (!push && pop) begin
            count_d = count_q - C_ONE;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         fifo_rd_q     <= '0;
         fifo_wr_q     <= '0;
         ifq_rd_q      <= '0;
         ifq_wr_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
            ifq_addr_q[i]   <= '0;
         end
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_wr_q     <= fifo_wr_d;
         ifq_rd_q      <= ifq_rd_d;
         ifq_wr_q      <= ifq_wr_d;
         fifo_instr_q  <= fifo_instr_d;
         fifo_pc_q     <= fifo_pc_d;
         ifq_addr_q    <= ifq_addr_d;
      end
   end

   a_rvalid_has_request : assert property (@(posedge clk_i) disable iff (rst_i)
      imem_rvalid_i |-> (outstanding_q != '0))
      else $error("imem_rvalid_i with no outstanding request");

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_unit
// Directed + random bench for instr_fetch_unit with memory model and scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_instr_fetch_unit;

   localparam int          AW       = 32;
   localparam int          DW       = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic          clk_i         = 1'b0;
   logic          rst_i         = 1'b1;
   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic          imem_gnt_i    = 1'b0;
   logic          imem_rvalid_i = 1'b0;
   logic [DW-1:0] imem_rdata_i  = '0;
   logic          redirect_i    = 1'b0;
   logic [AW-1:0] redirect_pc_i = '0;
   logic          instr_valid_o;
   logic [DW-1:0] instr_o;
   logic [AW-1:0] pc_o;
   logic [AW-1:0] pc_plus4_o;
   logic          instr_ready_i = 1'b0;

   instr_fetch_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESET_PC   (RESET_PC),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .instr_ready_i (instr_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int          vec    = 0;
   int          err    = 0;
   int          cyc    = 0;
   int          last_t = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   logic [31:0] mpc    = RESET_PC;
   logic [31:0] exp_q  [$];
   logic [31:0] pend_a [$];
   int          pend_t [$];
   logic        s_valid, s_req, s_rv;
   logic [31:0] s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive at posedge+1, sample/score mid-cycle, advance to next posedge+1.
   task automatic tick(input logic rdy, input logic gnt, input logic redir, input logic [31:0] tgt);
      logic [31:0] e;
      int          t;
      instr_ready_i = rdy;
      imem_gnt_i    = gnt;
      redirect_i    = redir;
      redirect_pc_i = tgt;
      s_rv          = (pend_a.size() != 0) && (pend_t[0] <= cyc);
      imem_rvalid_i = s_rv;
      imem_rdata_i  = s_rv ? mem_word(pend_a[0]) : 32'hDEAD_BEEF;
      #4;
      s_valid = instr_valid_o;
      s_req   = imem_req_o;
      s_addr  = imem_addr_o;
      if (redir) chk("req_in_redirect", {31'b0, s_req}, 32'd0);
      if (!s_valid) begin
         chk("nop_when_invalid", instr_o, 32'h0000_0013);
         chk("pc_zero_when_invalid", pc_o, 32'd0);
         chk("pcp4_zero_when_invalid", pc_plus4_o, 32'd0);
      end
      if (redir) begin
         exp_q.delete();
         mpc = tgt;
      end else if (s_valid && rdy) begin
         chk("sb_has_expected", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc_o", pc_o, e);
            chk("instr_o", instr_o, mem_word(e));
            chk("pc_plus4_o", pc_plus4_o, e + 32'd4);
         end
      end
      if (s_req && gnt) begin
         chk("req_addr", s_addr, mpc);
         exp_q.push_back(mpc);
         t = cyc + int'($urandom_range(lat_hi, lat_lo));
         if (t <= last_t) t = last_t + 1;
         last_t = t;
         pend_a.push_back(s_addr);
         pend_t.push_back(t);
         mpc = mpc + 32'd4;
      end
      if (s_rv) begin
         void'(pend_a.pop_front());
         void'(pend_t.pop_front());
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst_i         = 1'b1;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      redirect_i    = 1'b0;
      instr_ready_i = 1'b1;
      #1;
      chk("rst_req", {31'b0, imem_req_o}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'h0000_0013);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_pcp4", pc_plus4_o, 32'd0);
      exp_q.delete();
      pend_a.delete();
      pend_t.delete();
      last_t = cyc;
      mpc    = RESET_PC;
      @(posedge clk_i); #1; cyc++;
      @(posedge clk_i); #1; cyc++;
      rst_i = 1'b0;
      #1;
      chk("post_rst_req", {31'b0, imem_req_o}, 32'd1);
      chk("post_rst_addr", imem_addr_o, RESET_PC);
   endtask

   initial begin
      @(posedge clk_i); #1;
      apply_reset();

      // Zero-wait memory: first valid two cycles after first request, then one per cycle.
      lat_lo = 1; lat_hi = 1;
      tick(1'b1, 1'b1, 1'b0, '0); chk("lat_c0_valid", {31'b0, s_valid}, 32'd0);
      tick(1'b1, 1'b1, 1'b0, '0); chk("lat_c1_valid", {31'b0, s_valid}, 32'd0);
      tick(1'b1, 1'b1, 1'b0, '0); chk("lat_c2_valid", {31'b0, s_valid}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b1, 1'b0, '0);
         chk("sustained_valid", {31'b0, s_valid}, 32'd1);
      end

      // Decode stall: requests stop once credits are exhausted, no words lost.
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, '0);
      chk("stall_req_low", {31'b0, s_req}, 32'd0);
      chk("stall_valid", {31'b0, s_valid}, 32'd1);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, '0);

      // Mid-stream reset.
      apply_reset();
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, '0);

      // Redirect with requests in flight at latency 3.
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      tick(1'b1, 1'b1, 1'b0, '0);
      chk("redir_req", {31'b0, s_req}, 32'd1);
      chk("redir_addr", s_addr, 32'h0000_0100);
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0, '0);

      // Redirect coinciding with rvalid and a would-be pop.
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      chk("t5_rvalid_in_redirect", {31'b0, s_rv}, 32'd1);
      chk("t5_valid_in_redirect", {31'b0, s_valid}, 32'd1);
      tick(1'b1, 1'b1, 1'b0, '0);
      chk("t5_empty_after", {31'b0, s_valid}, 32'd0);
      chk("t5_addr_after", s_addr, 32'h0000_0200);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, '0);

      // PC wrap-around at the top of the address space.
      tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, '0);

      // Random grant/latency/stall/redirect mix.
      lat_lo = 1; lat_hi = 5;
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(99, 0) < 75), ($urandom_range(99, 0) < 70),
              ($urandom_range(99, 0) < 4),
              32'h0000_1000 | {22'b0, 8'($urandom_range(255, 0)), 2'b00});
      end
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
`default_nettype wire
